// File: rtl/decryption_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decryption_scheduler_if : upstream, engine and result signals of the
// decryption scheduler. Revision 1.0
// ---------------------------------------------------------------------------
interface decryption_scheduler_if #(
  parameter int D_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [1:0]           select_i;
  logic                 ready_o;
  logic [D_WIDTH-1:0]   eng_data_o;
  logic [2:0]           eng_valid_o;
  logic [2:0]           eng_busy_i;
  logic [3*D_WIDTH-1:0] eng_data_i;
  logic [2:0]           eng_valid_i;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 busy_o;
  logic                 err_o;

  modport slave (
    input  data_i, valid_i, select_i, eng_busy_i, eng_data_i, eng_valid_i,
    output ready_o, eng_data_o, eng_valid_o, data_o, valid_o, busy_o, err_o
  );

  modport master (
    output data_i, valid_i, select_i, eng_busy_i, eng_data_i, eng_valid_i,
    input  ready_o, eng_data_o, eng_valid_o, data_o, valid_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/decryption_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decryption_scheduler : routes a message to one of three decryption engines
// and relays the selected engine's output. Revision 1.0
// ---------------------------------------------------------------------------
module decryption_scheduler #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(8'hFA),
  parameter int                 WAIT_TIMEOUT           = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  decryption_scheduler_if.slave   bus
);

  localparam int             CW         = $clog2(MAX_NOF_CHARS + 1);
  localparam int             TW         = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0]  MAX_CNT    = CW'(MAX_NOF_CHARS);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [1:0]         sel, sel_n;
  logic [CW-1:0]      count, count_n;
  logic [TW-1:0]      timer, timer_n;
  logic [D_WIDTH-1:0] eng_data_q, eng_data_n;
  logic [2:0]         eng_valid_q, eng_valid_n;
  logic [D_WIDTH-1:0] data_q, data_n;
  logic               valid_q, valid_n;
  logic               err_q, err_n;

  logic               accept;
  logic               is_token;
  logic [3:0]         busy_pad;
  logic [3:0]         valid_pad;
  logic [D_WIDTH-1:0] eng_lane [4];

  // Fourth lane keeps the 2-bit select index in range; it is never selected.
  generate
    for (genvar k = 0; k < 3; k++) begin : g_lane
      assign eng_lane[k] = bus.eng_data_i[k*D_WIDTH +: D_WIDTH];
    end
  endgenerate
  assign eng_lane[3] = '0;
  assign busy_pad    = {1'b0, bus.eng_busy_i};
  assign valid_pad   = {1'b0, bus.eng_valid_i};

  assign bus.ready_o = (state == IDLE) || (state == LOAD);
  assign bus.busy_o  = (state != IDLE);
  assign accept      = bus.valid_i && bus.ready_o;
  assign is_token    = (bus.data_i == START_DECRYPTION_TOKEN);

  always_comb begin
    state_n     = state;
    sel_n       = sel;
    count_n     = count;
    timer_n     = timer;
    eng_data_n  = eng_data_q;
    eng_valid_n = 3'b000;
    data_n      = '0;
    valid_n     = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if ((bus.select_i != 2'd3) && !is_token) begin
            sel_n       = bus.select_i;
            count_n     = CW'(1);
            eng_data_n  = bus.data_i;
            eng_valid_n = 3'b001 << bus.select_i;
            state_n     = LOAD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (is_token) begin
            eng_data_n  = bus.data_i;
            eng_valid_n = 3'b001 << sel;
            timer_n     = '0;
            state_n     = WAIT;
          end else if (count < MAX_CNT) begin
            eng_data_n  = bus.data_i;
            eng_valid_n = 3'b001 << sel;
            count_n     = count + 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WAIT: begin
        // Busy seen on the final timeout cycle still wins over the timeout.
        if (busy_pad[sel]) begin
          state_n = DRAIN;
        end else if (timer == TIMER_LAST) begin
          err_n   = 1'b1;
          count_n = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DRAIN: begin
        valid_n = valid_pad[sel];
        data_n  = valid_pad[sel] ? eng_lane[sel] : '0;
        if (!busy_pad[sel]) begin
          count_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= 2'd0;
      count       <= '0;
      timer       <= '0;
      eng_data_q  <= '0;
      eng_valid_q <= 3'b000;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      count       <= count_n;
      timer       <= timer_n;
      eng_data_q  <= eng_data_n;
      eng_valid_q <= eng_valid_n;
      data_q      <= data_n;
      valid_q     <= valid_n;
      err_q       <= err_n;
    end
  end

  assign bus.eng_data_o  = eng_data_q;
  assign bus.eng_valid_o = eng_valid_q;
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_decryption_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decryption_scheduler : directed and randomized message traffic against
// a message-level model of the scheduler. Revision 1.0
// ---------------------------------------------------------------------------
module tb_decryption_scheduler;

  localparam int         DW   = 8;
  localparam int         MAXC = 50;
  localparam int         WT   = 4;
  localparam logic [7:0] TOK  = 8'hFA;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decryption_scheduler_if #(.D_WIDTH(DW)) bus ();

  decryption_scheduler #(
    .D_WIDTH(DW),
    .MAX_NOF_CHARS(MAXC),
    .START_DECRYPTION_TOKEN(TOK),
    .WAIT_TIMEOUT(WT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.data_i      = '0;
    bus.valid_i     = 1'b0;
    bus.select_i    = 2'd0;
    bus.eng_busy_i  = 3'b000;
    bus.eng_data_i  = '0;
    bus.eng_valid_i = 3'b000;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s);
    bus.data_i   = d;
    bus.select_i = s;
    bus.valid_i  = 1'b1;
    tick();
    bus.valid_i  = 1'b0;
  endtask

  // One whole message: chars to engine s, token, engine handshake, drain.
  // busy_delay < 0 means the engine never answers.
  task automatic run_msg(input logic [1:0] s, input logic [7:0] chars[$], input bit chaos,
                         input int busy_delay, input logic [7:0] outs[$], input bit rnd_valid);
    logic [2:0]  strobe;
    logic [1:0]  ss;
    logic [23:0] lanes;
    bit          v;
    bit          last;
    strobe = 3'b001 << s;
    clear_inputs();
    foreach (chars[i]) begin
      ss = (i == 0 || !chaos) ? s : 2'($urandom_range(0, 3));
      send(chars[i], ss);
      if (i < MAXC) begin
        chk("fwd_strobe", bus.eng_valid_o, strobe);
        chk("fwd_data", bus.eng_data_o, chars[i]);
        chk("fwd_err", bus.err_o, 0);
      end else begin
        chk("ovf_strobe", bus.eng_valid_o, 0);
        chk("ovf_err", bus.err_o, 1);
      end
    end
    send(TOK, chaos ? 2'($urandom_range(0, 3)) : s);
    chk("tok_strobe", bus.eng_valid_o, strobe);
    chk("tok_data", bus.eng_data_o, TOK);
    chk("tok_busy", bus.busy_o, 1);
    chk("tok_ready", bus.ready_o, 0);

    if (busy_delay < 0) begin
      for (int c = 1; c <= WT; c++) begin
        bus.eng_busy_i = 3'($urandom) & ~strobe;
        tick();
        chk("to_err", bus.err_o, (c == WT));
        chk("to_ready", bus.ready_o, (c == WT));
        chk("to_strobe", bus.eng_valid_o, 0);
      end
      bus.eng_busy_i = 3'b000;
      tick();
      chk("to_err_single", bus.err_o, 0);
      return;
    end

    for (int c = 0; c < busy_delay; c++) begin
      bus.eng_busy_i  = 3'($urandom) & ~strobe;
      bus.eng_valid_i = 3'($urandom);
      bus.eng_data_i  = 24'($urandom);
      bus.valid_i     = 1'($urandom);
      bus.data_i      = 8'($urandom);
      tick();
      bus.valid_i = 1'b0;
      chk("wait_valid", bus.valid_o, 0);
      chk("wait_strobe", bus.eng_valid_o, 0);
      chk("wait_err", bus.err_o, 0);
      chk("wait_busy", bus.busy_o, 1);
    end

    bus.eng_busy_i  = strobe | (3'($urandom) & ~strobe);
    bus.eng_valid_i = 3'($urandom);
    bus.eng_data_i  = 24'($urandom);
    tick();
    chk("enter_valid", bus.valid_o, 0);
    chk("enter_busy", bus.busy_o, 1);

    foreach (outs[j]) begin
      last  = (j == outs.size() - 1);
      v     = rnd_valid ? 1'($urandom) : 1'b1;
      lanes = 24'($urandom);
      lanes[s*8 +: 8] = outs[j];
      bus.eng_data_i  = lanes;
      bus.eng_valid_i = (3'($urandom) & ~strobe) | (v ? strobe : 3'b000);
      bus.eng_busy_i  = (3'($urandom) & ~strobe) | (last ? 3'b000 : strobe);
      bus.valid_i     = 1'($urandom);
      bus.data_i      = 8'($urandom);
      tick();
      bus.valid_i = 1'b0;
      chk("drain_valid", bus.valid_o, v);
      chk("drain_data", bus.data_o, v ? outs[j] : 8'h00);
      chk("drain_busy", bus.busy_o, !last);
      chk("drain_strobe", bus.eng_valid_o, 0);
      chk("drain_err", bus.err_o, 0);
    end

    clear_inputs();
    tick();
    chk("post_valid", bus.valid_o, 0);
    chk("post_data", bus.data_o, 0);
    chk("post_ready", bus.ready_o, 1);
  endtask

  initial begin
    logic [7:0] cq[$];
    logic [7:0] oq[$];
    logic [7:0] d;
    int         bd;

    clear_inputs();
    #3;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_strobe", bus.eng_valid_o, 0);
    chk("rst_eng_data", bus.eng_data_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_err", bus.err_o, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Caesar/zigzag style directed message: "abc" to engine 2, engine returns "cab".
    cq = '{8'h61, 8'h62, 8'h63};
    oq = '{8'h63, 8'h61, 8'h62};
    run_msg(2'd2, cq, 1'b0, 1, oq, 1'b0);

    // Invalid select and bare token in IDLE.
    send(8'h41, 2'd3);
    chk("inv_err", bus.err_o, 1);
    chk("inv_strobe", bus.eng_valid_o, 0);
    chk("inv_busy", bus.busy_o, 0);
    tick();
    chk("inv_err_single", bus.err_o, 0);
    send(TOK, 2'd0);
    chk("idle_tok_err", bus.err_o, 1);
    chk("idle_tok_strobe", bus.eng_valid_o, 0);
    tick();

    // 51 characters to engine 0, then a silent engine.
    cq = {};
    for (int i = 0; i < MAXC + 1; i++) begin
      d = 8'($urandom);
      cq.push_back((d == TOK) ? 8'h00 : d);
    end
    oq = {};
    run_msg(2'd0, cq, 1'b0, -1, oq, 1'b0);

    // Select changes mid-load must not move the strobe.
    cq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    oq = '{8'h20};
    run_msg(2'd0, cq, 1'b1, 0, oq, 1'b0);

    // Busy raised on the last allowed wait cycle.
    cq = '{8'h30};
    oq = '{8'h31, 8'h32};
    run_msg(2'd1, cq, 1'b0, WT - 1, oq, 1'b1);

    // Randomized messages.
    for (int m = 0; m < 14; m++) begin
      cq = {};
      oq = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        d = 8'($urandom);
        cq.push_back((d == TOK) ? 8'h00 : d);
      end
      for (int i = 0; i < int'($urandom_range(1, 5)); i++) oq.push_back(8'($urandom));
      bd = int'($urandom_range(0, WT));
      run_msg(2'($urandom_range(0, 2)), cq, 1'b1, (bd == WT) ? -1 : bd, oq, 1'b1);
    end

    // Reset in the middle of a drain.
    clear_inputs();
    send(8'h55, 2'd1);
    send(TOK, 2'd1);
    bus.eng_busy_i = 3'b010;
    tick();
    bus.eng_valid_i = 3'b010;
    bus.eng_data_i  = 24'h00_77_00;
    tick();
    chk("pre_rst_valid", bus.valid_o, 1);
    chk("pre_rst_data", bus.data_o, 8'h77);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.valid_o, 0);
    chk("async_rst_busy", bus.busy_o, 0);
    chk("async_rst_ready", bus.ready_o, 1);
    chk("async_rst_data", bus.data_o, 0);
    tick();
    chk("in_rst_strobe", bus.eng_valid_o, 0);
    tick();
    rst_n = 1'b1;
    clear_inputs();
    tick();
    chk("after_rst_ready", bus.ready_o, 1);
    chk("after_rst_strobe", bus.eng_valid_o, 0);
    cq = '{8'h01, 8'h02};
    oq = '{8'h03, 8'h04};
    run_msg(2'd0, cq, 1'b0, 2, oq, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decryption_scheduler.md
DECRYPTION_SCHEDULER -- requirements
Module: decryption_scheduler

Interface
REQ-001 Parameter D_WIDTH, 8, character width in bits; SHALL size all data ports.
REQ-002 Parameter MAX_NOF_CHARS, 50, maximum characters per message; SHALL bound the character counter.
REQ-003 Parameter START_DECRYPTION_TOKEN, 8'hFA, end-of-message / start-decryption marker.
REQ-004 Parameter WAIT_TIMEOUT, 4, cycles allowed for the engine to raise busy after the token.
REQ-005 Ports SHALL be exactly as follows:
- clk  in  1  system clock; the block SHALL use one clock, rising edge.
- rst_n  in  1  reset; SHALL be asynchronous and active-low.
- data_i  in  D_WIDTH  encrypted character or token.
- valid_i  in  1  data_i qualifier.
- select_i  in  2  target engine: 0 caesar, 1 scytale, 2 zigzag, 3 invalid.
- ready_o  out  1  scheduler accepts data_i this cycle.
- eng_data_o  out  D_WIDTH  character broadcast to all engines.
- eng_valid_o  out  3  one-hot write strobe per engine.
- eng_busy_i  in  3  per-engine busy.
- eng_data_i  in  3*D_WIDTH  per-engine decrypted output; engine k uses bits [k*D_WIDTH +: D_WIDTH].
- eng_valid_i  in  3  per-engine output valid.
- data_o  out  D_WIDTH  decrypted character.
- valid_o  out  1  data_o qualifier.
- busy_o  out  1  message in flight (state != IDLE).
- err_o  out  1  one-cycle error pulse.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, WAIT, DRAIN.
REQ-007 ready_o SHALL be decoded from state: 1 in IDLE and LOAD, 0 in WAIT and DRAIN.
REQ-008 valid_i while ready_o=0 SHALL be ignored: no forward, no error.
REQ-009 IDLE, accepted char with select_i<3 and data_i!=token: latch sel=select_i, count=1, forward, go to LOAD.
REQ-010 IDLE, select_i=3 or data_i=token: discard, err_o=1 for one cycle, stay in IDLE.
REQ-011 Forwarding: eng_data_o=data_i and eng_valid_o=(1<<sel) SHALL be registered with 1-cycle latency; eng_valid_o SHALL be all-zero otherwise.
REQ-012 LOAD: select_i SHALL be ignored; sel is locked until return to IDLE.
REQ-013 LOAD, non-token char with count<MAX_NOF_CHARS: forward it, count+1.
REQ-014 LOAD, non-token char with count=MAX_NOF_CHARS: drop it, err_o pulse, stay in LOAD.
REQ-015 LOAD, token: forward the token to sel, clear timer, go to WAIT.
REQ-016 WAIT: eng_busy_i[sel]=1 SHALL move the FSM to DRAIN.
REQ-017 WAIT: if eng_busy_i[sel] stays 0 for WAIT_TIMEOUT cycles, err_o pulse and return to IDLE.
REQ-018 DRAIN: data_o<=eng_data_i[sel] and valid_o<=eng_valid_i[sel], registered, 1-cycle latency.
- data_o SHALL be 0 whenever valid_o=0.
- Unselected engines SHALL be ignored.
REQ-019 DRAIN: eng_busy_i[sel] falling to 0 SHALL return the FSM to IDLE and clear count.
- A final eng_valid_i[sel] in that same cycle SHALL still be output.
REQ-020 count width SHALL be clog2(MAX_NOF_CHARS+1); count SHALL never wrap.
REQ-021 err_o SHALL be registered and SHALL never be high for two consecutive cycles from one event.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, sel=0, count=0, timer=0.
REQ-023 rst_n=0 SHALL force eng_data_o=0, eng_valid_o=0, data_o=0, valid_o=0, busy_o=0, err_o=0.
REQ-024 Reset mid-message SHALL abandon the message without emitting any further strobe; ready_o=1 after release.

Verification
REQ-025 Select 2, chars 8'h61,8'h62,8'h63, then token.
- eng_valid_o=3'b100 for 4 cycles.
- Engine busy and outputs "cab" -> data_o 8'h63,8'h61,8'h62 with valid_o.
- IDLE after busy falls.
REQ-026 select_i=3 with 8'h41 in IDLE -> err_o one pulse, eng_valid_o=0, busy_o=0.
REQ-027 51 chars to engine 0 with MAX_NOF_CHARS=50 -> 50 strobes, err_o on 51st; the token still forwarded.
REQ-028 Token sent, engine never raises busy -> err_o 4 cycles after token; return to IDLE; ready_o=1.
REQ-029 Select_i changed 0->1 mid-LOAD -> all strobes remain 3'b001.
REQ-030 Reset asserted during DRAIN -> valid_o=0 and busy_o=0 asynchronously; the next message is accepted normally.
